// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per
// clock, with zero-divisor and quotient-overflow short-cuts that finish in a single cycle.
module seq_divider #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0]   Divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   Quotient,
   output logic [WIDTH-1:0]   Remainder,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] low;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   trial;
   logic             ge;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // rem < dvsr always holds, so the top bit of the partial remainder is implicitly 0 and the
   // W-bit modular difference is exact whenever trial >= dvsr.
   always_comb begin
      trial   = {rem, low[WIDTH-1]};
      ge      = (trial >= {1'b0, dvsr});
      diff    = trial[WIDTH-1:0] - dvsr;
      rem_nxt = ge ? diff : trial[WIDTH-1:0];
      quo_nxt = {low[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         busy        <= 1'b0;
         done        <= 1'b0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         rem         <= '0;
         low         <= '0;
         dvsr        <= '0;
         cnt         <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (Divisor == '0) begin
                     Quotient    <= '1;
                     Remainder   <= Dividend[WIDTH-1:0];
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     done        <= 1'b1;
                     state       <= StDone;
                  end else if (Dividend[2*WIDTH-1:WIDTH] >= Divisor) begin
                     Quotient    <= '1;
                     Remainder   <= '0;
                     div_by_zero <= 1'b0;
                     overflow    <= 1'b1;
                     done        <= 1'b1;
                     state       <= StDone;
                  end else begin
                     rem   <= Dividend[2*WIDTH-1:WIDTH];
                     low   <= Dividend[WIDTH-1:0];
                     dvsr  <= Divisor;
                     cnt   <= CW'(WIDTH - 1);
                     state <= StRun;
                  end
               end
            end
            StRun: begin
               // The low-half shift register fills with quotient bits as dividend bits leave it.
               rem <= rem_nxt;
               low <= quo_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  Quotient    <= quo_nxt;
                  Remainder   <= rem_nxt;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  done        <= 1'b1;
                  state       <= StDone;
               end
            end
            StDone: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and corner-sequence bench for seq_divider (WIDTH=16).
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] Dividend;
   logic [15:0] Divisor;
   logic        busy, done, div_by_zero, overflow;
   logic [15:0] Quotient, Remainder;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   seq_divider #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .Dividend(Dividend), .Divisor(Divisor),
      .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   typedef struct {
      logic [31:0] dd;
      logic [15:0] dv;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Starts one operation and returns the done latency (0 on timeout) and busy-high cycle count;
   // returns one cycle after done, sampled #1 after the edge.
   task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                         output int lat, output int bcyc, output logic post_idle);
      @(negedge clk);
      Dividend = dd;
      Divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      Dividend = $urandom;
      Divisor  = 16'($urandom);
      lat  = 0;
      bcyc = 0;
      post_idle = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (busy) bcyc++;
         if (done) begin
            lat = i;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (lat != 0) begin
         @(posedge clk);
         #1;
         post_idle = !busy && !done;
      end
   endtask

   vec_t vecs[11];
   int   lat, bcyc, d0;
   logic idle;
   logic [15:0] a, b, r;
   logic [31:0] dd;

   initial begin
      vecs[0]  = '{32'h0001_86A0, 16'h0007, 16'h37CD, 16'h0005, 1'b0, 1'b0, 17};
      vecs[1]  = '{32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
      vecs[2]  = '{32'h0000_1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1};
      vecs[3]  = '{32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1};
      vecs[4]  = '{32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 17};
      vecs[5]  = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1};
      vecs[6]  = '{32'h0000_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
      vecs[7]  = '{32'h0005_0000, 16'h0010, 16'h5000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[8]  = '{32'h0000_0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[9]  = '{32'hFFFF_0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1};
      vecs[10] = '{32'h0000_03E8, 16'h03E8, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};

      rst = 1'b1;
      start = 1'b0;
      Dividend = '0;
      Divisor = '0;
      #12;
      check("reset_outputs", {busy, done, div_by_zero, overflow, Quotient, Remainder}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].dd, vecs[i].dv, lat, bcyc, idle);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'(vecs[i].lat));
         check($sformatf("v%0d_idle_after", i), 64'(idle), 64'd1);
         check($sformatf("v%0d_result", i), {Quotient, Remainder, div_by_zero, overflow},
               {vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf});
      end

      // Round-trip sweep: Dividend = A*B + r with r < B always leaves a W-bit quotient.
      for (int n = 0; n < 1000; n++) begin
         a  = 16'($urandom);
         b  = 16'($urandom_range(1, 65535));
         r  = 16'($urandom_range(0, int'(b) - 1));
         dd = 32'(a) * 32'(b) + 32'(r);
         run_op(dd, b, lat, bcyc, idle);
         check("sweep", {Quotient, Remainder, div_by_zero, overflow, 16'(lat)},
               {a, r, 1'b0, 1'b0, 16'd17});
      end

      // A start pulse mid-RUN must be ignored; a start right after done must be accepted.
      d0 = done_cnt;
      @(negedge clk);
      Dividend = 32'h0001_86A0;
      Divisor  = 16'h0007;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      Dividend = 32'h0000_1234;
      Divisor  = 16'h0000;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            lat = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("midrun_done_seen", 64'(lat), 64'd1);
      check("midrun_result", {Quotient, Remainder, div_by_zero, overflow},
            {16'h37CD, 16'h0005, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      run_op(32'h0000_0064, 16'h0007, lat, bcyc, idle);
      check("b2b_latency", 64'(lat), 64'd17);
      check("b2b_result", {Quotient, Remainder}, {16'h000E, 16'h0002});
      repeat (30) @(negedge clk);
      check("midrun_done_pulses", 64'(done_cnt - d0), 64'd2);

      // Asynchronous reset during RUN iteration 8 discards the operation.
      @(negedge clk);
      Dividend = 32'hFFFE_0001;
      Divisor  = 16'hFFFF;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      d0  = done_cnt;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", {busy, done, div_by_zero, overflow, Quotient, Remainder},
            64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("reset_no_done", 64'(done_cnt - d0), 64'd0);
      run_op(32'h0001_86A0, 16'h0007, lat, bcyc, idle);
      check("post_reset_op", {Quotient, Remainder, 16'(lat)}, {16'h37CD, 16'h0005, 16'd17});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
